// File: rtl/constellation_persist_renderer_if.sv
// Symbol input and 720p video output bundle for constellation_persist_renderer.
interface constellation_persist_renderer_if #(
  parameter int DATA_W   = 12,
  parameter int MAX_DOTS = 64
);
  logic signed [DATA_W-1:0]    sym_I;
  logic signed [DATA_W-1:0]    sym_Q;
  logic                        sym_valid;
  logic [23:0]                 rgb_pixel;
  logic                        hsync;
  logic                        vsync;
  logic                        de;
  logic [$clog2(MAX_DOTS):0]   dot_count;

  modport master (
    output sym_I, sym_Q, sym_valid,
    input  rgb_pixel, hsync, vsync, de, dot_count
  );

  modport slave (
    input  sym_I, sym_Q, sym_valid,
    output rgb_pixel, hsync, vsync, de, dot_count
  );
endinterface

// File: rtl/constellation_persist_renderer.sv
// 720p60 constellation plotter with per-dot frame persistence and youngest-dot colouring.
// Optional plot grid and decision lines compiled in with CONST_RENDER_GRID_EN.
module constellation_persist_renderer #(
  parameter int MAX_DOTS       = 64,
  parameter int DOT_SIZE       = 2,
  parameter int SCALE_SHIFT    = 4,
  parameter int PERSIST_FRAMES = 8,
  parameter int DATA_W         = 12
) (
  input  logic                          clk_pixel,
  input  logic                          rst_n,
  constellation_persist_renderer_if.slave bus
);
  localparam int AW   = $clog2(MAX_DOTS);
  localparam int CW   = AW + 1;
  localparam int STEP = 224 / PERSIST_FRAMES;

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        frame_tick;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == 11'd1649) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == 10'd749) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign frame_tick = (h_cnt == 11'd0) && (v_cnt == 10'd720);

  // Symbol to plot coordinates, clamped into the 640x640 plot window
  logic signed [DATA_W-1:0] i_sh, q_sh;
  logic signed [12:0]       x_raw, y_raw;
  logic [9:0]               x_map, y_map;

  always_comb begin
    i_sh  = bus.sym_I >>> SCALE_SHIFT;
    q_sh  = bus.sym_Q >>> SCALE_SHIFT;
    x_raw = 13'sd640 + 13'(i_sh);
    y_raw = 13'sd360 - 13'(q_sh);
    if (x_raw < 13'sd320)      x_map = 10'd320;
    else if (x_raw > 13'sd959) x_map = 10'd959;
    else                       x_map = x_raw[9:0];
    if (y_raw < 13'sd40)       y_map = 10'd40;
    else if (y_raw > 13'sd679) y_map = 10'd679;
    else                       y_map = y_raw[9:0];
  end

  logic [9:0]          dot_x   [MAX_DOTS];
  logic [9:0]          dot_y   [MAX_DOTS];
  logic [3:0]          dot_age [MAX_DOTS];
  logic [MAX_DOTS-1:0] dot_vld;
  logic [AW-1:0]       wr_ptr;

  // A slot being written this cycle takes the new dot and skips the frame ageing
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      dot_vld <= '0;
      for (int unsigned i = 0; i < MAX_DOTS; i++) begin
        dot_x[i]   <= '0;
        dot_y[i]   <= '0;
        dot_age[i] <= '0;
      end
    end else begin
      if (bus.sym_valid) wr_ptr <= wr_ptr + AW'(1);
      for (int unsigned i = 0; i < MAX_DOTS; i++) begin
        if (bus.sym_valid && (wr_ptr == AW'(i))) begin
          dot_x[i]   <= x_map;
          dot_y[i]   <= y_map;
          dot_age[i] <= '0;
          dot_vld[i] <= 1'b1;
        end else if (frame_tick && dot_vld[i]) begin
          dot_age[i] <= dot_age[i] + 4'd1;
          if (dot_age[i] == 4'(PERSIST_FRAMES - 1)) dot_vld[i] <= 1'b0;
        end
      end
    end
  end

  logic [CW-1:0] live_cnt;

  always_comb begin
    live_cnt = '0;
    for (int unsigned i = 0; i < MAX_DOTS; i++) live_cnt = live_cnt + CW'(dot_vld[i]);
  end

  assign bus.dot_count = live_cnt;

  logic [11:0] h12, v12;
  logic        hit;
  logic [3:0]  min_age;

  always_comb begin
    h12     = {1'b0, h_cnt};
    v12     = {2'b0, v_cnt};
    hit     = 1'b0;
    min_age = '1;
    for (int unsigned i = 0; i < MAX_DOTS; i++) begin
      if (dot_vld[i] &&
          (h12 >= {2'b0, dot_x[i]}) && (h12 < {2'b0, dot_x[i]} + 12'(DOT_SIZE)) &&
          (v12 >= {2'b0, dot_y[i]}) && (v12 < {2'b0, dot_y[i]} + 12'(DOT_SIZE))) begin
        hit = 1'b1;
        if (dot_age[i] < min_age) min_age = dot_age[i];
      end
    end
  end

  logic        active, in_plot;
  logic [7:0]  green, red_blue;
  logic [23:0] rgb_next;

  always_comb begin
    active   = (h_cnt < 11'd1280) && (v_cnt < 10'd720);
    in_plot  = (h_cnt >= 11'd320) && (h_cnt <= 11'd959) &&
               (v_cnt >= 10'd40)  && (v_cnt <= 10'd679);
    green    = 8'd255 - 8'(int'(min_age) * STEP);
    red_blue = {2'b00, green[7:2]};
    rgb_next = '0;
    if (active) begin
      if (hit) begin
        rgb_next = {red_blue, green, red_blue};
      end
`ifdef CONST_RENDER_GRID_EN
      else if (in_plot && ((h_cnt == 11'd320) || (h_cnt == 11'd959) || (h_cnt == 11'd640) ||
                           (v_cnt == 10'd40)  || (v_cnt == 10'd679) || (v_cnt == 10'd360))) begin
        rgb_next = 24'h606060;
      end else if (in_plot && ((int'(h_cnt) == 640 - (1296 >>> SCALE_SHIFT)) ||
                               (int'(h_cnt) == 640 + (1296 >>> SCALE_SHIFT)) ||
                               (int'(v_cnt) == 360 - (1296 >>> SCALE_SHIFT)) ||
                               (int'(v_cnt) == 360 + (1296 >>> SCALE_SHIFT)))) begin
        rgb_next = 24'h303030;
      end
`endif
      else if (in_plot) begin
        rgb_next = 24'h101010;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      bus.rgb_pixel <= '0;
      bus.hsync     <= 1'b0;
      bus.vsync     <= 1'b0;
      bus.de        <= 1'b0;
    end else begin
      bus.rgb_pixel <= rgb_next;
      bus.hsync     <= (h_cnt >= 11'd1390) && (h_cnt <= 11'd1429);
      bus.vsync     <= (v_cnt >= 10'd725) && (v_cnt <= 10'd729);
      bus.de        <= active;
    end
  end
endmodule

// File: tb/tb_constellation_persist_renderer.sv
// Bench for constellation_persist_renderer: two instances (SCALE_SHIFT 4 and 0) against a dot-list model.
module tb_constellation_persist_renderer;
  localparam int MAXD = 64;
  localparam int DS   = 2;
  localparam int SH0  = 4;
  localparam int SH1  = 0;
  localparam int PF   = 8;
  localparam int DW   = 12;

  logic clk_pixel = 1'b0;
  logic rst_n     = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  constellation_persist_renderer_if #(.DATA_W(DW), .MAX_DOTS(MAXD)) bus0 ();
  constellation_persist_renderer_if #(.DATA_W(DW), .MAX_DOTS(MAXD)) bus1 ();

  constellation_persist_renderer #(
    .MAX_DOTS(MAXD), .DOT_SIZE(DS), .SCALE_SHIFT(SH0), .PERSIST_FRAMES(PF), .DATA_W(DW)
  ) dut0 (.clk_pixel(clk_pixel), .rst_n(rst_n), .bus(bus0));

  constellation_persist_renderer #(
    .MAX_DOTS(MAXD), .DOT_SIZE(DS), .SCALE_SHIFT(SH1), .PERSIST_FRAMES(PF), .DATA_W(DW)
  ) dut1 (.clk_pixel(clk_pixel), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    int i;
    int q;
    int age;
  } dot_t;

  dot_t        dots[$];
  int          tb_h, tb_v;
  int          vectors = 0;
  int          miscompares = 0;
  logic [10:0] jh;
  logic [9:0]  jv;
  int          rec_i[$], rec_q[$];

  function automatic int map_x(int i, int sh);
    int x = 640 + (i >>> sh);
    return (x < 320) ? 320 : ((x > 959) ? 959 : x);
  endfunction

  function automatic int map_y(int q, int sh);
    int y = 360 - (q >>> sh);
    return (y < 40) ? 40 : ((y > 679) ? 679 : y);
  endfunction

  function automatic logic [31:0] exp_video(int h, int v, int sh);
    logic [23:0] rgb = '0;
    int best = 99;
    int g, x, y, dec;
    bit active = (h < 1280) && (v < 720);
    bit plot   = (h >= 320) && (h <= 959) && (v >= 40) && (v <= 679);
    bit hs     = (h >= 1390) && (h < 1430);
    bit vs     = (v >= 725) && (v < 730);
    dec = 1296 >>> sh;
    if (active) begin
      foreach (dots[k]) begin
        x = map_x(dots[k].i, sh);
        y = map_y(dots[k].q, sh);
        if (h >= x && h < x + DS && v >= y && v < y + DS && dots[k].age < best) best = dots[k].age;
      end
      if (best < 99) begin
        g   = 255 - best * (224 / PF);
        rgb = {8'(g / 4), 8'(g), 8'(g / 4)};
      end
`ifdef CONST_RENDER_GRID_EN
      else if (plot && (h == 320 || h == 959 || h == 640 || v == 40 || v == 679 || v == 360))
        rgb = 24'h606060;
      else if (plot && (h == 640 - dec || h == 640 + dec || v == 360 - dec || v == 360 + dec))
        rgb = 24'h303030;
`endif
      else if (plot) rgb = 24'h101010;
    end
    return {5'b0, rgb, hs, vs, active};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] vid0();
    return {5'b0, bus0.rgb_pixel, bus0.hsync, bus0.vsync, bus0.de};
  endfunction

  function automatic logic [31:0] vid1();
    return {5'b0, bus1.rgb_pixel, bus1.hsync, bus1.vsync, bus1.de};
  endfunction

  task automatic step(input bit sv, input int i, input int q);
    logic [31:0] e0, e1;
    int ph, pv;
    bit tick;
    ph   = tb_h;
    pv   = tb_v;
    e0   = exp_video(ph, pv, SH0);
    e1   = exp_video(ph, pv, SH1);
    tick = (ph == 0) && (pv == 720);
    bus0.sym_valid = sv; bus0.sym_I = DW'(i); bus0.sym_Q = DW'(q);
    bus1.sym_valid = sv; bus1.sym_I = DW'(i); bus1.sym_Q = DW'(q);
    @(posedge clk_pixel);
    if (tick) begin
      dot_t keep[$];
      foreach (dots[k])
        if (dots[k].age + 1 < PF) keep.push_back('{i: dots[k].i, q: dots[k].q, age: dots[k].age + 1});
      dots = keep;
    end
    if (sv) begin
      dots.push_back('{i: i, q: q, age: 0});
      if (dots.size() > MAXD) void'(dots.pop_front());
    end
    if (tb_h == 1649) begin
      tb_h = 0;
      tb_v = (tb_v == 749) ? 0 : tb_v + 1;
    end else tb_h++;
    @(negedge clk_pixel);
    bus0.sym_valid = 1'b0;
    bus1.sym_valid = 1'b0;
    chk($sformatf("video0 h=%0d v=%0d", ph, pv), vid0(), e0);
    chk($sformatf("video1 h=%0d v=%0d", ph, pv), vid1(), e1);
    chk("count0", 32'(bus0.dot_count), 32'(dots.size()));
    chk("count1", 32'(bus1.dot_count), 32'(dots.size()));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0);
  endtask

  task automatic jump(input int h, input int v);
    jh = 11'(h);
    jv = 10'(v);
    force dut0.h_cnt = jh;
    force dut0.v_cnt = jv;
    force dut1.h_cnt = jh;
    force dut1.v_cnt = jv;
    #1;
    release dut0.h_cnt;
    release dut0.v_cnt;
    release dut1.h_cnt;
    release dut1.v_cnt;
    tb_h = h;
    tb_v = v;
  endtask

  task automatic probe(input int x, input int y);
    jump(x - 1, y);
    idle(DS + 2);
  endtask

  task automatic frame_tick_run();
    jump(1648, 719);
    idle(4);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " video0"}, vid0(), 32'd0);
    chk({tag, " video1"}, vid1(), 32'd0);
    chk({tag, " count0"}, 32'(bus0.dot_count), 32'd0);
    chk({tag, " count1"}, 32'(bus1.dot_count), 32'd0);
  endtask

  initial begin
    bus0.sym_valid = 1'b0; bus0.sym_I = '0; bus0.sym_Q = '0;
    bus1.sym_valid = 1'b0; bus1.sym_I = '0; bus1.sym_Q = '0;
    tb_h = 0;
    tb_v = 0;
    repeat (2) @(negedge clk_pixel);
    check_zero("reset");
    rst_n = 1'b1;

    // One full line plus the vertical sync window and frame wrap
    idle(1700);
    jump(1600, 724); idle(100);
    jump(1600, 729); idle(100);
    jump(1640, 749); idle(20);

    // Single dot: draw, age out over PF frame ticks
    jump(0, 100);
    step(1'b1, 648, 648);
    jump(680, 320); step(1'b0, 0, 0);
    chk("dot 680,320", 32'(bus0.rgb_pixel), 32'h3FFF3F);
    probe(680, 320); probe(680, 321); probe(680, 322);
    probe(959, 40);
    for (int t = 0; t < PF; t++) begin
      frame_tick_run();
      probe(680, 320);
      probe(959, 40);
    end
    chk("dot expired", 32'(bus0.dot_count), 32'd0);

    // Symbol coincident with frame tick
    jump(0, 200);
    step(1'b1, 648, 648);
    jump(1648, 719);
    idle(2);
    step(1'b1, 664, 648);
    jump(680, 320); step(1'b0, 0, 0);
    chk("aged dot", 32'(bus0.rgb_pixel), 32'h38E338);
    step(1'b0, 0, 0);
    chk("young wins", 32'(bus0.rgb_pixel), 32'h3FFF3F);
    probe(680, 320); probe(959, 40);

    // Overflow: MAXD+3 random strobes
    for (int t = 0; t < PF; t++) frame_tick_run();
    jump(0, 100);
    for (int k = 0; k < MAXD + 3; k++) begin
      int ri, rq;
      ri = int'($urandom_range(4095)) - 2048;
      rq = int'($urandom_range(4095)) - 2048;
      rec_i.push_back(ri);
      rec_q.push_back(rq);
      step(1'b1, ri, rq);
    end
    chk("count full", 32'(bus0.dot_count), 32'(MAXD));
    foreach (rec_i[k]) begin
      probe(map_x(rec_i[k], SH0), map_y(rec_q[k], SH0));
      probe(map_x(rec_i[k], SH1), map_y(rec_q[k], SH1));
    end

    // Clamp extremes at SCALE_SHIFT 0
    for (int t = 0; t < PF; t++) frame_tick_run();
    jump(0, 100);
    step(1'b1, -2048, -2048);
    probe(320, 679);
    probe(512, 488);

    // Asynchronous reset mid-frame with live dots
    rec_i.delete();
    rec_q.delete();
    jump(0, 100);
    for (int k = 0; k < 10; k++) begin
      int ri, rq;
      ri = int'($urandom_range(4095)) - 2048;
      rq = int'($urandom_range(4095)) - 2048;
      rec_i.push_back(ri);
      rec_q.push_back(rq);
      step(1'b1, ri, rq);
    end
    jump(500, 300);
    idle(3);
    rst_n = 1'b0;
    #1;
    check_zero("mid reset");
    repeat (2) @(negedge clk_pixel);
    rst_n = 1'b1;
    dots.delete();
    tb_h = 0;
    tb_v = 0;
    idle(5);
    foreach (rec_i[k]) probe(map_x(rec_i[k], SH0), map_y(rec_q[k], SH0));
    chk("after reset", 32'(bus0.dot_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/constellation_persist_renderer.md
CONSTELLATION_PERSIST_RENDERER -- requirements
Module: constellation_persist_renderer

Interface
REQ-001 SHALL have parameter MAX_DOTS, default 64, dot buffer depth (power of 2, 8..256).
REQ-002 SHALL have parameter DOT_SIZE, default 2, square dot edge in pixels (1..4).
REQ-003 SHALL have parameter SCALE_SHIFT, default 4, arithmetic right shift applied to I/Q before pixel mapping (0..6).
REQ-004 SHALL have parameter PERSIST_FRAMES, default 8, frames a dot remains visible (1..15).
REQ-005 SHALL have parameter DATA_W, default 12, I/Q sample width (Q1.(DATA_W-1)).
REQ-006 Port: clk_pixel, in, 1, 74.25 MHz pixel clock; the only clock.
REQ-007 Port: rst_n, in, 1, asynchronous active-low reset.
REQ-008 Port: sym_I, sym_Q, in, DATA_W signed, symbol coordinates, already synchronous to clk_pixel.
REQ-009 Port: sym_valid, in, 1, one-cycle strobe qualifying sym_I/sym_Q.
REQ-010 Port: rgb_pixel, out, 24, R[23:16] G[15:8] B[7:0].
REQ-011 Port: hsync, vsync, de, out, 1 each, 720p60 CEA-861 timing, active-high.
REQ-012 Port: dot_count, out, $clog2(MAX_DOTS)+1, number of live dots.

Function
REQ-013 SHALL generate 1650x750 total / 1280x720 active timing (HFP 110, HSYNC 40, HBP 220; VFP 5, VSYNC 5, VBP 20) from h/v counters wrapping at 1649/749.
REQ-014 hsync, vsync, de, rgb_pixel SHALL be registered, all aligned, one clk_pixel after the counter value they describe.
REQ-015 Mapping: x = 640 + (I >>> SCALE_SHIFT), y = 360 - (Q >>> SCALE_SHIFT), computed sign-extended in 13 bits, then clamped to plot area x 320..959, y 40..679.
REQ-016 Each sym_valid cycle SHALL write one dot (x, y, age 0, valid) at wr_ptr and increment wr_ptr modulo MAX_DOTS; no back-pressure.
REQ-017 Full buffer: new dot SHALL overwrite the oldest entry; dot_count saturates at MAX_DOTS.
REQ-018 Frame tick = first cycle of v_cnt==720, h_cnt==0; each valid dot's age SHALL increment; a dot reaching age PERSIST_FRAMES SHALL be invalidated and dot_count decremented.
REQ-019 Frame tick and sym_valid in the same cycle: new dot written with age 0 and not aged; all other dots aged; dot_count reflects both.
REQ-020 Hit: pixel (h,v) in active area with dot_x <= h < dot_x+DOT_SIZE and dot_y <= v < dot_y+DOT_SIZE for any valid dot.
REQ-021 Hit colour: green channel = 255 - (min_age * (224 / PERSIST_FRAMES)) over hitting dots, R = B = min green/4; youngest dot wins.
REQ-022 Non-hit priority: grid (if compiled) > plot background 0x101010 > outside plot 0x000000; blanking SHALL output 0x000000.
REQ-023 Hit test MAY be pipelined; total pipeline latency SHALL be compensated so sync/de/rgb remain aligned per REQ-014.

Reset
REQ-024 On rst_n low: counters 0, wr_ptr 0, all dots invalid, ages 0, dot_count 0, hsync/vsync/de 0, rgb_pixel 0x000000, asynchronously.
REQ-025 Reset mid-frame SHALL discard all dots; first frame after release starts at h=0, v=0.

Configuration
REQ-026 Macro CONST_RENDER_GRID_EN defined: draw 0x606060 on plot border and center axes (x=320,959,640; y=40,679,360) and 0x303030 on decision lines at center +/- (1296 >>> SCALE_SHIFT).
REQ-027 Macro undefined: no grid or decision logic; those pixels show plot background.

Verification
REQ-028 Reset release, no symbols, one frame -> hsync high for h 1390..1429, vsync high for v 725..729, de high 1280x720 cycles, dot_count 0.
REQ-029 Defaults, sym_I=648, sym_Q=648 one strobe -> 2x2 pixel at x 680..681, y 320..321 rgb 0x3FFF3F next frame; dot gone after 8 frame ticks, dot_count back to 0.
REQ-030 sym_I=-2048, sym_Q=-2048, SCALE_SHIFT=0 -> dot clamped to x=320, y=679.
REQ-031 MAX_DOTS+3 strobes within one frame -> dot_count = MAX_DOTS, first three dots not drawn, last MAX_DOTS drawn.
REQ-032 sym_valid coincident with frame tick -> new dot age 0 (full brightness); pre-existing dot age 1.
REQ-033 Assert rst_n low at v=300 with 10 live dots -> outputs zero immediately; after release dot_count 0 and no dots drawn.
